// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a window of register-file addresses, captures each
// word through the combinational read port and streams it out over a
// valid/ready interface with its address, keeping a modulo-256 checksum.
module reg_dump_reader #(
  parameter int unsigned pw = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [pw-1:0] start_addr,
  input  logic [pw:0]   count,
  input  logic          abort,
  output logic [pw-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic [7:0]    out_data,
  output logic [pw-1:0] out_addr,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic [7:0]    checksum
);

  localparam int unsigned DEPTH = 1 << pw;
  localparam logic [pw:0] FULL_CNT = (pw+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [pw-1:0] r_ptr;
  logic [pw:0]   r_rem;
  logic [7:0]    r_data;
  logic [pw-1:0] r_addr;
  logic          r_last;
  logic          r_valid;
  logic          r_busy;
  logic          r_done;
  logic [7:0]    r_sum;
  logic          w_hs;
  logic [pw:0]   w_eff_cnt;

  assign w_hs      = r_valid & out_ready;
  // zero and anything beyond the file size both mean a full-file dump
  assign w_eff_cnt = ((count == '0) || (count > FULL_CNT)) ? FULL_CNT : count;

  assign rd_addr   = r_ptr;
  assign out_data  = r_data;
  assign out_addr  = r_addr;
  assign out_last  = r_last;
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign checksum  = r_sum;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state logic; abort beats everything outside IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = abort ? S_IDLE : S_SEND;
      S_SEND: begin
        if (abort)     w_state_nxt = S_IDLE;
        else if (w_hs) w_state_nxt = r_last ? S_DONE : S_FETCH;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // datapath: pointer, remaining count, output word, checksum, status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_rem   <= '0;
      r_data  <= '0;
      r_addr  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
    end else begin
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
      r_valid <= (w_state_nxt == S_SEND);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ptr <= start_addr;
            r_rem <= w_eff_cnt;
            r_sum <= '0;
          end
        end
        S_FETCH: begin
          if (abort) begin
            r_last <= 1'b0;
          end else begin
            r_data <= rd_data;
            r_addr <= r_ptr;
            r_last <= (r_rem == (pw+1)'(1));
          end
        end
        S_SEND: begin
          if (abort) begin
            r_last <= 1'b0;
          end else if (w_hs) begin
            r_sum <= r_sum + r_data;
            if (!r_last) begin
              r_ptr <= r_ptr + pw'(1);
              r_rem <= r_rem - (pw+1)'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
